// File: rtl/ram_burst_reader_pkg.sv
// rtl/ram_burst_reader_pkg.sv - shared constants, state encoding and beat type for the burst reader
package ram_burst_reader_pkg;

   localparam int RAM_WIDTH = 16;
   localparam int RAM_DEPTH = 8;
   localparam int ADDR_SIZE = 3;
   localparam int LEN_SIZE  = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [LEN_SIZE-1:0] LEN_ZERO = '0;
   localparam logic [LEN_SIZE-1:0] LEN_ONE  = {{(LEN_SIZE-1){1'b0}}, 1'b1};

   // One buffered word together with its end-of-burst marker
   typedef struct packed {
      logic                 last;
      logic [RAM_WIDTH-1:0] data;
   } beat_t;

   // Next RAM address, wrapping from the top word back to word 0
   function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
      logic [ADDR_SIZE-1:0] top;
      top = ADDR_SIZE'(RAM_DEPTH - 1);
      if (a == top) begin
         return '0;
      end
      return a + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/ram_burst_reader_rd_skid_buf.sv
// rtl/ram_burst_reader_rd_skid_buf.sv - two-entry FIFO holding returned RAM words until the consumer takes them
module rd_skid_buf #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         empty
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_ptr_q;
   logic         wr_ptr_d;
   logic         rd_ptr_q;
   logic         rd_ptr_d;
   logic [1:0]   count_q;
   logic [1:0]   count_d;
   logic         push_ok;
   logic         pop_ok;

   // Qualify strobes: pop only with data present, push only when a slot is free or freed this cycle
   always_comb begin
      pop_ok  = pop && (count_q != 2'd0);
      push_ok = push && ((count_q != 2'd2) || pop_ok);
   end

   // Next storage contents, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers, emptied by clr
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == 2'd0);

   // The upstream credit rule must never push into a full buffer without a matching pop
   assert property (@(posedge clk) disable iff (clr) !(push && !pop_ok && (count_q == 2'd2)));

endmodule

// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - issues a burst of RAM reads and streams the returned words with last marking
module ram_burst_reader
   import ram_burst_reader_pkg::*;
(
   input  logic                 rd_clk,
   input  logic                 clr,
   input  logic                 start,
   input  logic [ADDR_SIZE-1:0] start_addr,
   input  logic [LEN_SIZE-1:0]  burst_len,
   output logic                 re,
   output logic [ADDR_SIZE-1:0] rd_addr,
   input  logic [RAM_WIDTH-1:0] ram_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [RAM_WIDTH-1:0] m_data,
   output logic                 m_last,
   output logic                 busy,
   output logic                 done
);

   logic [1:0]           state_q;
   logic [1:0]           state_d;
   logic [ADDR_SIZE-1:0] addr_q;
   logic [ADDR_SIZE-1:0] addr_d;
   logic [LEN_SIZE-1:0]  issue_rem_q;
   logic [LEN_SIZE-1:0]  issue_rem_d;
   logic [LEN_SIZE-1:0]  beat_rem_q;
   logic [LEN_SIZE-1:0]  beat_rem_d;
   logic                 inflight_q;
   logic                 inflight_d;
   logic                 inflight_last_q;
   logic                 inflight_last_d;
   logic                 done_q;
   logic                 done_d;

   logic                 issue;
   logic                 pop;
   logic                 credit_ok;
   logic [2:0]           occupancy;
   logic [1:0]           buf_count;
   logic                 buf_empty;
   beat_t                push_beat;
   beat_t                head_beat;

   // Read credit: words buffered plus the one in flight, less a word leaving now, must stay below two
   always_comb begin
      pop       = !buf_empty && m_ready;
      occupancy = {1'b0, buf_count} + {2'b00, inflight_q};
      credit_ok = occupancy < (3'd2 + {2'b00, pop});
      issue     = (state_q == ST_READ) && (issue_rem_q != LEN_ZERO) && credit_ok;
   end

   // Sequencer next state: burst load, address/length bookkeeping and completion
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      issue_rem_d     = issue_rem_q;
      beat_rem_d      = beat_rem_q;
      inflight_d      = issue;
      inflight_last_d = issue && (issue_rem_q == LEN_ONE);
      done_d          = (state_q == ST_DRAIN) && pop && (beat_rem_q == LEN_ONE);

      if (pop && (beat_rem_q != LEN_ZERO)) begin
         beat_rem_d = beat_rem_q - LEN_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (start && (burst_len != LEN_ZERO)) begin
               state_d     = ST_READ;
               addr_d      = start_addr;
               issue_rem_d = burst_len;
               beat_rem_d  = burst_len;
            end
         end
         ST_READ: begin
            if (issue) begin
               addr_d      = next_addr(addr_q);
               issue_rem_d = issue_rem_q - LEN_ONE;
               if (issue_rem_q == LEN_ONE) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && (beat_rem_q == LEN_ONE)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers; clr aborts any burst and drops in-flight reads
   always_ff @(posedge rd_clk or posedge clr) begin
      if (clr) begin
         state_q         <= ST_IDLE;
         addr_q          <= '0;
         issue_rem_q     <= '0;
         beat_rem_q      <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         issue_rem_q     <= issue_rem_d;
         beat_rem_q      <= beat_rem_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         done_q          <= done_d;
      end
   end

   // The word read last cycle is on ram_data now and enters the buffer at this edge
   always_comb begin
      push_beat.last = inflight_last_q;
      push_beat.data = ram_data;
   end

   rd_skid_buf #(
      .W($bits(beat_t))
   ) u_buf (
      .clk       (rd_clk),
      .clr       (clr),
      .push      (inflight_q),
      .push_data (push_beat),
      .pop       (pop),
      .head      (head_beat),
      .count     (buf_count),
      .empty     (buf_empty)
   );

   assign re      = issue;
   assign rd_addr = addr_q;
   assign m_valid = !buf_empty;
   assign m_data  = head_beat.data;
   assign m_last  = head_beat.last;
   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb/tb_ram_burst_reader.sv - scoreboard bench for ram_burst_reader with a registered-read RAM model
module tb_ram_burst_reader;

   logic        rd_clk = 1'b0;
   logic        clr;
   logic        start;
   logic [2:0]  start_addr;
   logic [3:0]  burst_len;
   logic        re;
   logic [2:0]  rd_addr;
   logic [15:0] ram_data = 16'h0000;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic        m_last;
   logic        busy;
   logic        done;

   ram_burst_reader dut (
      .rd_clk     (rd_clk),
      .clr        (clr),
      .start      (start),
      .start_addr (start_addr),
      .burst_len  (burst_len),
      .re         (re),
      .rd_addr    (rd_addr),
      .ram_data   (ram_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 rd_clk = ~rd_clk;

   logic [15:0] ram_mem [8];
   initial begin
      for (int i = 0; i < 8; i++) ram_mem[i] = 16'h00A0 + 16'(i);
   end

   always @(posedge rd_clk) begin
      if (re) ram_data <= ram_mem[rd_addr];
   end

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int start_cyc = 0;
   int re_cnt = 0;
   int hs_cnt = 0;
   int done_cnt = 0;
   int outstanding = 0;
   int max_out = 0;
   int first_re_cyc = -1;
   int last_re_cyc = -1;
   int first_valid_cyc = -1;
   logic [2:0]  exp_addr_q [$];
   logic [16:0] exp_beat_q [$];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = 16'h0;
   logic        prev_last = 1'b0;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   initial forever begin
      @(posedge rd_clk);
      cyc++;
   end

   // monitor / scoreboard
   initial forever begin
      logic [16:0] exp;
      @(negedge rd_clk);
      if (clr) begin
         prev_stall  = 1'b0;
         outstanding = 0;
      end else begin
         if (re) begin
            re_cnt++;
            outstanding++;
            if (first_re_cyc < 0) first_re_cyc = cyc;
            last_re_cyc = cyc;
            if (exp_addr_q.size() == 0) check_eq("re_unexpected", re, 0);
            else check_eq("rd_addr", rd_addr, exp_addr_q.pop_front());
         end
         if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (prev_stall) begin
            check_eq("hold_valid", m_valid, 1);
            check_eq("hold_data", m_data, prev_data);
            check_eq("hold_last", m_last, prev_last);
         end
         if (m_valid && m_ready) begin
            hs_cnt++;
            outstanding--;
            if (exp_beat_q.size() == 0) begin
               check_eq("beat_unexpected", m_valid, 0);
            end else begin
               exp = exp_beat_q.pop_front();
               check_eq("m_data", m_data, exp[15:0]);
               check_eq("m_last", m_last, exp[16]);
            end
         end
         if (outstanding > max_out) max_out = outstanding;
         if (done) begin
            done_cnt++;
            check_eq("busy_in_done_cycle", busy, 0);
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic clear_stats();
      re_cnt = 0; hs_cnt = 0; done_cnt = 0; max_out = 0;
      first_re_cyc = -1; last_re_cyc = -1; first_valid_cyc = -1;
   endtask

   task automatic expect_burst(input int a, input int len);
      for (int i = 0; i < len; i++) begin
         logic [2:0]  ad;
         logic [15:0] d;
         ad = 3'((a + i) % 8);
         d  = 16'h00A0 + 16'(ad);
         exp_addr_q.push_back(ad);
         exp_beat_q.push_back({(i == len - 1), d});
      end
   endtask

   task automatic issue_start(input int a, input int len);
      start      = 1'b1;
      start_addr = 3'(a);
      burst_len  = 4'(len);
      start_cyc  = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic run_until_done(input int mode, input int budget);
      for (int n = 0; n < budget; n++) begin
         if (exp_beat_q.size() == 0 && done_cnt > 0) break;
         if (mode == 1) m_ready = ~m_ready;
         else m_ready = 1'b1;
         tick();
      end
      check_eq("burst_complete", (exp_beat_q.size() == 0 && done_cnt > 0), 1);
      m_ready = 1'b1;
      tick();
      tick();
      check_eq("done_once", done_cnt, 1);
      check_eq("busy_after", busy, 0);
      check_eq("addr_queue_empty", exp_addr_q.size(), 0);
   endtask

   initial begin
      clr = 1'b1; start = 1'b0; start_addr = 3'd0; burst_len = 4'd0; m_ready = 1'b0;
      repeat (3) tick();
      check_eq("rst_re", re, 0);
      check_eq("rst_rd_addr", rd_addr, 0);
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_m_data", m_data, 0);
      check_eq("rst_m_last", m_last, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      clr = 1'b0;
      tick();

      // full burst, consumer always ready
      clear_stats();
      m_ready = 1'b1;
      expect_burst(0, 8);
      issue_start(0, 8);
      run_until_done(0, 60);
      check_eq("t1_re_latency", first_re_cyc - start_cyc, 1);
      check_eq("t1_valid_latency", first_valid_cyc - first_re_cyc, 2);
      check_eq("t1_re_consecutive", last_re_cyc - first_re_cyc, 7);
      check_eq("t1_re_count", re_cnt, 8);
      check_eq("t1_handshakes", hs_cnt, 8);

      // address wrap
      clear_stats();
      expect_burst(6, 4);
      issue_start(6, 4);
      run_until_done(0, 60);
      check_eq("t2_re_count", re_cnt, 4);

      // backpressure right after the first word
      clear_stats();
      m_ready = 1'b0;
      expect_burst(0, 8);
      issue_start(0, 8);
      for (int n = 0; n < 20 && !m_valid; n++) tick();
      check_eq("t3_first_valid", m_valid, 1);
      repeat (5) tick();
      check_eq("t3_re_stalled", re_cnt, 2);
      check_eq("t3_head_data", m_data, 16'h00A0);
      check_eq("t3_still_valid", m_valid, 1);
      run_until_done(0, 60);
      check_eq("t3_handshakes", hs_cnt, 8);
      check_eq("t3_max_outstanding_le2", (max_out <= 2), 1);

      // toggling ready
      clear_stats();
      m_ready = 1'b0;
      expect_burst(2, 7);
      issue_start(2, 7);
      run_until_done(1, 80);
      check_eq("t4_handshakes", hs_cnt, 7);
      check_eq("t4_max_outstanding_le2", (max_out <= 2), 1);

      // start while busy, then zero-length start
      clear_stats();
      m_ready = 1'b1;
      expect_burst(1, 5);
      issue_start(1, 5);
      tick();
      issue_start(3, 9);
      run_until_done(0, 60);
      check_eq("t5_re_count", re_cnt, 5);
      clear_stats();
      issue_start(4, 0);
      repeat (6) tick();
      check_eq("t5_zero_len_re", re_cnt, 0);
      check_eq("t5_zero_len_done", done_cnt, 0);
      check_eq("t5_zero_len_busy", busy, 0);

      // abort after three beats
      clear_stats();
      expect_burst(0, 8);
      issue_start(0, 8);
      for (int n = 0; n < 30 && hs_cnt < 3; n++) tick();
      check_eq("t6_three_beats", hs_cnt, 3);
      clr = 1'b1;
      #1;
      check_eq("t6_re", re, 0);
      check_eq("t6_rd_addr", rd_addr, 0);
      check_eq("t6_m_valid", m_valid, 0);
      check_eq("t6_m_data", m_data, 0);
      check_eq("t6_m_last", m_last, 0);
      check_eq("t6_busy", busy, 0);
      check_eq("t6_done", done, 0);
      exp_addr_q.delete();
      exp_beat_q.delete();
      tick();
      clr = 1'b0;
      clear_stats();
      repeat (3) tick();
      check_eq("t6_no_done", done_cnt, 0);
      check_eq("t6_no_re", re_cnt, 0);
      expect_burst(5, 3);
      issue_start(5, 3);
      run_until_done(0, 60);
      check_eq("t6_restart_latency", first_re_cyc - start_cyc, 1);
      check_eq("t6_restart_beats", hs_cnt, 3);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
